// File: rtl/queue_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
//
// Shared definitions for the queue occupancy counter:
//   QUEUE_WIDTH       default width of the occupancy count
//   DEBOUNCE_DEFAULT  default number of stable synchronized samples per edge
//   DEB_CNT_W         width of the debouncer stability counter (DEBOUNCE <= 255)
//   deb_state_t       debouncer FSM state encoding
// ---------------------------------------------------------------------------
package queue_pkg;

  localparam int unsigned QUEUE_WIDTH      = 3;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned DEB_CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHK_HIGH,
    IDLE_HIGH,
    CHK_LOW
  } deb_state_t;

  // True when one more stable sample completes the debounce window.
  function automatic logic deb_window_done(input logic [DEB_CNT_W-1:0] cnt,
                                           input logic [DEB_CNT_W-1:0] limit);
    return (cnt + DEB_CNT_W'(1)) == limit;
  endfunction

endpackage

// File: rtl/gate_debounce.sv
// ---------------------------------------------------------------------------
// gate_debounce
//
// Synchronizes one raw gate sensor, debounces it and emits a one-cycle pulse
// on every accepted rising edge of the debounced level.
//
// Parameters:
//   DEBOUNCE  consecutive identical synchronized samples needed to accept a
//             level change (1..255)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   i_sensor  raw asynchronous sensor level
//   o_evt     registered one-cycle pulse on an accepted rising edge
// ---------------------------------------------------------------------------
module gate_debounce
  import queue_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sensor,
  output logic o_evt
);

  localparam logic [DEB_CNT_W-1:0] DEB_LIMIT = DEB_CNT_W'(DEBOUNCE);
  // With a one-sample window the first opposite sample is already conclusive.
  localparam logic SINGLE = (DEBOUNCE == 1);

  logic                 r_sync1;
  logic                 r_sync2;
  deb_state_t           r_state;
  deb_state_t           w_state_next;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic [DEB_CNT_W-1:0] w_cnt_next;
  logic                 r_evt;
  logic                 w_evt_next;
  logic                 w_sample;
  logic                 w_done;

  // 2-flop synchronizer for the asynchronous sensor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
  assign w_done   = deb_window_done(r_cnt, DEB_LIMIT);

  // State and stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: the counter holds the run length of samples that
  // disagree with the currently accepted level.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_sample) begin
          if (SINGLE) begin
            w_state_next = IDLE_HIGH;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_HIGH;
            w_cnt_next   = DEB_CNT_W'(1);
          end
        end
      end
      CHK_HIGH: begin
        if (!w_sample) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = '0;
        end else if (w_done) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + DEB_CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!w_sample) begin
          if (SINGLE) begin
            w_state_next = IDLE_LOW;
            w_cnt_next   = '0;
          end else begin
            w_state_next = CHK_LOW;
            w_cnt_next   = DEB_CNT_W'(1);
          end
        end
      end
      CHK_LOW: begin
        if (w_sample) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = '0;
        end else if (w_done) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + DEB_CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic: pulse only when the rising direction is accepted.
  always_comb begin
    w_evt_next = 1'b0;
    if (w_sample) begin
      if (r_state == IDLE_LOW && SINGLE) begin
        w_evt_next = 1'b1;
      end else if (r_state == CHK_HIGH && w_done) begin
        w_evt_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_evt_next;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/queue_counter.sv
// ---------------------------------------------------------------------------
// queue_counter
//
// Queue occupancy counter fed by two debounced gate sensors. The back gate
// adds a person, the front gate removes one. The count saturates at 0 and
// MAX = 2^WIDTH-1; an entry when full or an exit when empty is rejected and
// raises a sticky error flag, cleared by the next accepted count-changing or
// simultaneous event.
//
// Parameters:
//   WIDTH     width of the occupancy count
//   DEBOUNCE  debounce window in synchronized samples (1..255)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   enter_sensor  raw back-gate sensor (high = beam broken)
//   leave_sensor  raw front-gate sensor
//   pcount        registered occupancy
//   error         registered sticky rejected-event flag
//   enter_evt     one-cycle debounced enter event pulse
//   leave_evt     one-cycle debounced leave event pulse
// ---------------------------------------------------------------------------
module queue_counter
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH    = QUEUE_WIDTH,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter_sensor,
  input  logic             leave_sensor,
  output logic [WIDTH-1:0] pcount,
  output logic             error,
  output logic             enter_evt,
  output logic             leave_evt
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             w_enter_evt;
  logic             w_leave_evt;
  logic [WIDTH-1:0] r_pcount;
  logic [WIDTH-1:0] w_pcount_next;
  logic             r_error;
  logic             w_error_next;

  gate_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_enter_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sensor (enter_sensor),
    .o_evt    (w_enter_evt)
  );

  gate_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_leave_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sensor (leave_sensor),
    .o_evt    (w_leave_evt)
  );

  // Saturating count update; a simultaneous enter and leave cancels out at
  // every occupancy, including the empty and full boundaries.
  always_comb begin
    w_pcount_next = r_pcount;
    w_error_next  = r_error;
    unique case ({w_enter_evt, w_leave_evt})
      2'b10: begin
        if (r_pcount != MAX) begin
          w_pcount_next = r_pcount + WIDTH'(1);
          w_error_next  = 1'b0;
        end else begin
          w_error_next = 1'b1;
        end
      end
      2'b01: begin
        if (r_pcount != '0) begin
          w_pcount_next = r_pcount - WIDTH'(1);
          w_error_next  = 1'b0;
        end else begin
          w_error_next = 1'b1;
        end
      end
      2'b11: begin
        w_error_next = 1'b0;
      end
      default: begin
        w_pcount_next = r_pcount;
        w_error_next  = r_error;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcount <= '0;
      r_error  <= 1'b0;
    end else begin
      r_pcount <= w_pcount_next;
      r_error  <= w_error_next;
    end
  end

  assign pcount    = r_pcount;
  assign error     = r_error;
  assign enter_evt = w_enter_evt;
  assign leave_evt = w_leave_evt;

endmodule

// File: tb/tb_queue_counter.sv
// ---------------------------------------------------------------------------
// tb_queue_counter
//
// Directed bench for queue_counter. A behavioural model derives events from
// the raw sensor stream (two-cycle synchronizer delay, then a run of
// DEBOUNCE disagreeing samples flips the accepted level) and applies the
// saturating count rules; every negedge compares the DUT with the model.
// Hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_queue_counter;

  localparam int D    = 4;
  localparam int W    = 3;
  localparam int MAXV = 7;

  logic         clk;
  logic         rst_n;
  logic         enter_sensor;
  logic         leave_sensor;
  logic [W-1:0] pcount;
  logic         error;
  logic         enter_evt;
  logic         leave_evt;

  int n_total = 0;
  int n_bad   = 0;
  int n_eevt  = 0;
  int n_levt  = 0;

  queue_counter #(
    .WIDTH    (W),
    .DEBOUNCE (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enter_sensor (enter_sensor),
    .leave_sensor (leave_sensor),
    .pcount       (pcount),
    .error        (error),
    .enter_evt    (enter_evt),
    .leave_evt    (leave_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  int m_pcount = 0;
  bit m_error  = 0;
  bit m_eevt   = 0;
  bit m_levt   = 0;
  bit e_d1 = 0, e_d2 = 0, l_d1 = 0, l_d2 = 0;
  bit e_lvl = 0, l_lvl = 0;
  int e_run = 0, l_run = 0;

  task automatic deb(input bit s, inout bit lvl, inout int run, output bit evt);
    evt = 1'b0;
    if (s != lvl) begin
      run++;
      if (run >= D) begin
        lvl = s;
        run = 0;
        evt = s;
      end
    end else begin
      run = 0;
    end
  endtask

  initial begin
    bit ne, nl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pcount = 0; m_error = 0; m_eevt = 0; m_levt = 0;
        e_d1 = 0; e_d2 = 0; l_d1 = 0; l_d2 = 0;
        e_lvl = 0; l_lvl = 0; e_run = 0; l_run = 0;
      end else begin
        // Count reacts to the events produced on the previous edge.
        if (m_eevt && m_levt) begin
          m_error = 0;
        end else if (m_eevt) begin
          if (m_pcount < MAXV) begin m_pcount++; m_error = 0; end
          else m_error = 1;
        end else if (m_levt) begin
          if (m_pcount > 0) begin m_pcount--; m_error = 0; end
          else m_error = 1;
        end
        // Debouncer sees the raw level captured two edges ago.
        deb(e_d2, e_lvl, e_run, ne);
        deb(l_d2, l_lvl, l_run, nl);
        m_eevt = ne;
        m_levt = nl;
        e_d2 = e_d1; e_d1 = enter_sensor;
        l_d2 = l_d1; l_d1 = leave_sensor;
      end
    end
  end

  // Per-cycle comparison against the model, plus event pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      check("pcount_vs_model", 32'(pcount), 32'(m_pcount));
      check("error_vs_model", 32'(error), 32'(m_error));
      check("enter_evt_vs_model", 32'(enter_evt), 32'(m_eevt));
      check("leave_evt_vs_model", 32'(leave_evt), 32'(m_levt));
      if (enter_evt === 1'b1) n_eevt++;
      if (leave_evt === 1'b1) n_levt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  // Advance n rising edges and land 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic e, input logic l, input int hi);
    enter_sensor = e;
    leave_sensor = l;
    tick(hi);
    enter_sensor = 1'b0;
    leave_sensor = 1'b0;
    tick(2 * D + 6);
  endtask

  task automatic expect_state(input string name, input int pc, input int er);
    check({name, "_pcount"}, 32'(pcount), 32'(pc));
    check({name, "_error"}, 32'(error), 32'(er));
  endtask

  initial begin
    rst_n        = 1'b0;
    enter_sensor = 1'b0;
    leave_sensor = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset_pcount", 32'(pcount), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_enter_evt", 32'(enter_evt), 32'd0);
    check("reset_leave_evt", 32'(leave_evt), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single entry: count steps exactly 6 edges after the rise.
    n_eevt = 0;
    enter_sensor = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("entry_timing_edge%0d", i), 32'(pcount), (i == 6) ? 32'd1 : 32'd0);
      if (i == 5) check("entry_evt_edge5", 32'(enter_evt), 32'd1);
    end
    tick(3);
    enter_sensor = 1'b0;
    tick(2 * D + 6);
    check("entry_single_pulse", 32'(n_eevt), 32'd1);
    expect_state("entry", 1, 0);

    // Glitch rejection at pcount=2.
    pulse(1'b1, 1'b0, D + 2);
    n_levt = 0;
    pulse(1'b0, 1'b1, 3);
    check("glitch_no_leave_evt", 32'(n_levt), 32'd0);
    expect_state("glitch", 2, 0);

    // Full boundary.
    repeat (5) pulse(1'b1, 1'b0, D + 2);
    expect_state("full", 7, 0);
    pulse(1'b1, 1'b0, D + 2);
    expect_state("full_reject", 7, 1);
    pulse(1'b0, 1'b1, D + 2);
    expect_state("full_leave", 6, 0);

    // Empty boundary.
    repeat (6) pulse(1'b0, 1'b1, D + 2);
    expect_state("drain", 0, 0);
    pulse(1'b0, 1'b1, D + 2);
    expect_state("empty_reject", 0, 1);
    pulse(1'b1, 1'b0, D + 2);
    expect_state("empty_enter", 1, 0);

    // Simultaneous events at 3, 0 (after an error) and 7 (after an error).
    repeat (2) pulse(1'b1, 1'b0, D + 2);
    pulse(1'b1, 1'b1, D + 2);
    expect_state("simul_at3", 3, 0);
    repeat (3) pulse(1'b0, 1'b1, D + 2);
    pulse(1'b0, 1'b1, D + 2);
    expect_state("pre_simul0", 0, 1);
    pulse(1'b1, 1'b1, D + 2);
    expect_state("simul_at0", 0, 0);
    repeat (8) pulse(1'b1, 1'b0, D + 2);
    expect_state("pre_simul7", 7, 1);
    pulse(1'b1, 1'b1, D + 2);
    expect_state("simul_at7", 7, 0);

    // Reset two cycles into an enter pulse; sensor stays high across release.
    n_eevt = 0;
    enter_sensor = 1'b1;
    tick(2);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid_pcount%0d", i), 32'(pcount), 32'd0);
      check($sformatf("rst_mid_evt%0d", i), 32'(enter_evt), 32'd0);
    end
    tick(1);
    rst_n = 1'b1;
    tick(D + 6);
    check("rst_release_one_evt", 32'(n_eevt), 32'd1);
    expect_state("rst_release", 1, 0);
    enter_sensor = 1'b0;
    tick(2 * D + 6);
    expect_state("final", 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
